// File: rtl/fetch_pkg.sv
`default_nettype none
// =====================================================================
// Package  : fetch_pkg
// Brief    : Shared state encoding and constants for the instruction fetch.
// Revision : 1.0 - initial release
// =====================================================================
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam int unsigned FETCH_BEATS       = 4;
  localparam int unsigned BEAT_W            = $clog2(FETCH_BEATS);

endpackage
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// =====================================================================
// Module   : imem_fetch
// Brief    : Reads a 32-bit little-endian instruction over four byte beats
//            and hands it to decode with a valid/ready handshake.
// Revision : 1.0 - initial release
// =====================================================================
module imem_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        flush,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        fetch_flag,
  output logic        fetch_err,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(FETCH_BEATS - 1);

  fetch_state_e      r_state;
  fetch_state_e      w_next_state;
  logic [31:2]       r_addr_hi;
  logic [BEAT_W-1:0] r_beat;
  logic              r_flush_pend;
  logic              w_aligned;

  assign w_aligned = (i_addr[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a flush only ends FETCH once the outstanding beat acks
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!flush) begin
          w_next_state = w_aligned ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          if (flush || r_flush_pend) begin
            w_next_state = ST_IDLE;
          end else if (r_beat == C_LAST_BEAT) begin
            w_next_state = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (flush || instr_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    mem_req     = (r_state == ST_FETCH);
    instr_valid = (r_state == ST_DONE);
  end

  assign fetch_flag = instr_valid & instr_ready & ~flush;
  assign mem_addr   = {r_addr_hi, r_beat};

  // Address latch, beat counter and byte assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_hi    <= '0;
      r_beat       <= '0;
      r_flush_pend <= 1'b0;
      instr        <= '0;
      fetch_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!flush) begin
            r_addr_hi <= i_addr[31:2];
            r_beat    <= '0;
            if (!w_aligned) begin
              instr     <= NOP_INSTR;
              fetch_err <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (mem_ack) begin
            instr[{r_beat, 3'b000} +: 8] <= mem_rdata;
            r_beat                       <= r_beat + 1'b1;
            r_flush_pend                 <= 1'b0;
            if (w_next_state == ST_DONE) begin
              fetch_err <= 1'b0;
            end
          end else if (flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// =====================================================================
// Module   : tb_imem_fetch
// Brief    : Directed and randomized checks of imem_fetch against a
//            transaction-level memory/PC model.
// Revision : 1.0 - initial release
// =====================================================================
module tb_imem_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_addr;
  logic        flush;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        fetch_flag;
  logic        fetch_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  int          n_checks = 0;
  int          n_errors = 0;
  int          nflag;
  int          idle;
  int          saw_valid;
  logic [31:0] exp_w;
  logic [31:0] prev_instr;
  logic        prev_err;
  logic        prev_hold;
  logic        last_flag;
  logic [31:0] q[$];

  imem_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_addr      (i_addr),
    .flush       (flush),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .fetch_flag  (fetch_flag),
    .fetch_err   (fetch_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  always #5 clk = ~clk;

  // Byte-wide instruction memory contents
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h10:  return 8'h93;
      32'h11:  return 8'h00;
      32'h12:  return 8'h50;
      32'h13:  return 8'h00;
      default: return 8'((a * 32'd29) >> 3) ^ a[31:24] ^ 8'h5A;
    endcase
  endfunction

  assign mem_rdata = mem_byte(mem_addr);

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] base;
    base = a & 32'hFFFF_FFFC;
    if (a % 4 != 0) return NOP;
    return {mem_byte(base + 3), mem_byte(base + 2), mem_byte(base + 1), mem_byte(base)};
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFFC;
    if (sel <= 2) return $urandom;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clk_step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!instr_valid && n < 40) begin
      clk_step();
      @(negedge clk);
      n++;
    end
    if (!instr_valid) check(tag, 32'(instr_valid), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; instr_ready = 1'b1; mem_ack = 1'b1; i_addr = 32'h10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_instr", instr, 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_err",   32'(fetch_err), 32'd0);
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_maddr", mem_addr, 32'd0);
    check("rst_flag",  32'(fetch_flag), 32'd0);

    // Aligned fetch at 0x10 with ack and ready tied high
    clk_step(); rst_n = 1'b1;
    nflag = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("al_req", 32'(mem_req), 32'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) check("al_maddr", mem_addr, 32'(32'h10 + c - 1));
      check("al_valid", 32'(instr_valid), 32'(c == 5));
      if (c == 5) begin
        check("al_instr", instr, 32'h0050_0093);
        check("al_err", 32'(fetch_err), 32'd0);
      end
      nflag += int'(fetch_flag);
      clk_step();
      if (c == 5) begin
        i_addr = 32'h100;
        instr_ready = 1'b0;
      end
    end
    check("al_flags", nflag, 32'd1);

    // Back-pressure: ready low for three DONE cycles
    @(negedge clk);
    wait_valid("bp_timeout");
    exp_w = ref_word(32'h100);
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_instr", instr, exp_w);
      check("bp_err",   32'(fetch_err), 32'd0);
      check("bp_flag",  32'(fetch_flag), 32'd0);
      clk_step();
      if (k == 2) instr_ready = 1'b1;
      @(negedge clk);
    end
    check("bp_flag_rise", 32'(fetch_flag), 32'd1);
    check("bp_instr_hs", instr, exp_w);

    // Misaligned address
    clk_step(); i_addr = 32'h22;
    @(negedge clk);
    check("mis_idle_valid", 32'(instr_valid), 32'd0);
    check("mis_idle_req", 32'(mem_req), 32'd0);
    clk_step();
    @(negedge clk);
    check("mis_valid", 32'(instr_valid), 32'd1);
    check("mis_instr", instr, NOP);
    check("mis_err",   32'(fetch_err), 32'd1);
    check("mis_req",   32'(mem_req), 32'd0);
    check("mis_flag",  32'(fetch_flag), 32'd1);

    // Flush while beat 1 is outstanding, ack arrives two cycles late
    clk_step(); i_addr = 32'h80; mem_ack = 1'b0;
    @(negedge clk);
    saw_valid = int'(instr_valid);
    clk_step(); mem_ack = 1'b1;
    @(negedge clk);
    check("fl_addr0", mem_addr, 32'h80);
    clk_step(); mem_ack = 1'b0; flush = 1'b1; i_addr = 32'h40;
    @(negedge clk);
    check("fl_req_a", 32'(mem_req), 32'd1);
    check("fl_addr1", mem_addr, 32'h81);
    saw_valid += int'(instr_valid);
    clk_step(); flush = 1'b0;
    @(negedge clk);
    check("fl_req_b", 32'(mem_req), 32'd1);
    saw_valid += int'(instr_valid);
    clk_step(); mem_ack = 1'b1;
    @(negedge clk);
    check("fl_req_c", 32'(mem_req), 32'd1);
    check("fl_addr1_ack", mem_addr, 32'h81);
    saw_valid += int'(instr_valid);
    clk_step();
    @(negedge clk);
    check("fl_idle_req", 32'(mem_req), 32'd0);
    saw_valid += int'(instr_valid);
    check("fl_no_valid", saw_valid, 32'd0);
    clk_step(); instr_ready = 1'b0;
    @(negedge clk);
    check("fl_new_req", 32'(mem_req), 32'd1);
    check("fl_new_addr", mem_addr, 32'h40);
    wait_valid("fl_timeout");
    check("fl_instr", instr, ref_word(32'h40));

    // Flush and ready together in DONE
    clk_step(); flush = 1'b1; instr_ready = 1'b1;
    @(negedge clk);
    check("fr_flag", 32'(fetch_flag), 32'd0);
    check("fr_valid", 32'(instr_valid), 32'd1);
    clk_step(); flush = 1'b0;
    @(negedge clk);
    check("fr_idle_valid", 32'(instr_valid), 32'd0);
    check("fr_idle_req", 32'(mem_req), 32'd0);

    // Reset during beat 2
    for (int k = 0; k < 3; k++) begin
      clk_step();
      @(negedge clk);
      check("rm_addr", mem_addr, 32'(32'h40 + k));
    end
    #1 rst_n = 1'b0;
    #1;
    check("rm_req",   32'(mem_req), 32'd0);
    check("rm_maddr", mem_addr, 32'd0);
    check("rm_instr", instr, 32'd0);
    check("rm_valid", 32'(instr_valid), 32'd0);
    check("rm_err",   32'(fetch_err), 32'd0);
    check("rm_flag",  32'(fetch_flag), 32'd0);
    clk_step(); i_addr = 32'h200; rst_n = 1'b1;
    @(negedge clk);
    check("rm_idle_req", 32'(mem_req), 32'd0);
    clk_step();
    @(negedge clk);
    check("rm_restart_req", 32'(mem_req), 32'd1);
    check("rm_restart_addr", mem_addr, 32'h200);
    wait_valid("rm_timeout");
    check("rm_instr2", instr, ref_word(32'h200));

    // Randomized traffic; the bench acts as PC and memory
    last_flag = fetch_flag;
    prev_hold = 1'b0; prev_instr = '0; prev_err = 1'b0;
    idle = 0;
    q.delete();
    for (int c = 0; c < 4000; c++) begin
      clk_step();
      flush = ($urandom_range(0, 24) == 0);
      if (flush || last_flag) i_addr = rand_addr();
      mem_ack     = ($urandom_range(0, 2) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (prev_hold) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_instr", instr, prev_instr);
        check("hold_err", 32'(fetch_err), 32'(prev_err));
      end
      check("flag_rule", 32'(fetch_flag), 32'(instr_valid & instr_ready & ~flush));
      if (mem_req && mem_ack) q.push_back(mem_addr);
      if (fetch_flag) begin
        check("rnd_instr", instr, ref_word(i_addr));
        check("rnd_err", 32'(fetch_err), 32'(i_addr % 4 != 0));
        if (i_addr % 4 == 0) begin
          if (q.size() < 4) check("rnd_beats", q.size(), 32'd4);
          else
            for (int k = 0; k < 4; k++)
              check("rnd_beat_addr", q[q.size() - 4 + k], 32'(i_addr + k));
        end
        q.delete();
      end
      prev_hold  = instr_valid && !instr_ready && !flush;
      prev_instr = instr;
      prev_err   = fetch_err;
      last_flag  = fetch_flag;
      idle       = (fetch_flag || flush) ? 0 : idle + 1;
      if (idle > 60) begin
        check("rnd_stall", idle, 32'd60);
        idle = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imem_fetch.md
# imem_fetch

Instruction-fetch responder on the far side of the program counter's address interface. Samples the PC's `i_addr`, reads the 32-bit instruction little-endian from a byte-wide instruction memory over four request/acknowledge beats, and presents it to the decode stage with a valid/ready handshake. Pulses `fetch_flag` on delivery so the PC advances.

## Interface
- `NOP_INSTR`, 32'h0000_0013: instruction word delivered when a fetch is misaligned.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `i_addr` in 32: instruction address from the PC.
- `flush` in 1: discard the current/pending fetch; the next fetch uses the updated `i_addr`.
- `instr` out 32: assembled instruction word.
- `instr_valid` out 1: `instr` and `fetch_err` are valid.
- `instr_ready` in 1: decode accepts `instr`.
- `fetch_flag` out 1: one-cycle delivery pulse to the PC, equal to `instr_valid & instr_ready & ~flush`.
- `fetch_err` out 1: delivered word came from a misaligned address.
- `mem_req` out 1: byte read request.
- `mem_addr` out 32: byte address, `{addr_q[31:2], beat[1:0]}`.
- `mem_rdata` in 8: read byte, valid when `mem_ack` is high.
- `mem_ack` in 1: completes the current beat. Ignored while `mem_req` is low.

## Operation
- States are IDLE, FETCH and DONE. Internal registers are `addr_q[31:0]`, `beat[1:0]` and `instr`.
- **IDLE:**
  - If `flush` is high, stay in IDLE.
  - Otherwise latch `addr_q <= i_addr` and clear `beat`.
  - If `i_addr[1:0] == 0`, go to FETCH.
  - Otherwise set `instr <= NOP_INSTR`, `fetch_err <= 1`, and go to DONE without touching memory.
- **FETCH:**
  - `mem_req` is high every cycle.
  - On `mem_ack`, write `mem_rdata` into `instr[8*beat +: 8]` and increment `beat`.
  - On the ack with `beat == 3`, go to DONE with `fetch_err <= 0`.
- **FETCH with `flush`:**
  - A flush seen while a beat is outstanding is remembered in `flush_pend`.
  - `mem_req` stays high until that beat's ack; the request is never withdrawn early.
  - On that ack, go to IDLE and discard the word. `flush_pend` clears.
- **DONE:**
  - `instr_valid` is high.
  - `instr`, `instr_valid` and `fetch_err` stay stable until `instr_ready` is high.
  - On the handshake, `fetch_flag` pulses and the state goes to IDLE.
  - If `flush` is high in DONE, go to IDLE with no `fetch_flag`. `flush` wins over a simultaneous `instr_ready`.
- **Address rules:**
  - `mem_addr` never carries into `addr_q[31:2]`. 32'hFFFF_FFFC reads bytes FC–FF with no wrap to 0.
  - Only the low two bits of `i_addr` are checked for alignment.

## Timing
- **Reset values:** state IDLE; `addr_q`, `beat`, `instr` = 0; `instr_valid`, `fetch_err`, `mem_req`, `fetch_flag` = 0; `mem_addr` = 0; `flush_pend` = 0.
- **`i_addr` sampling:** sampled only in IDLE, which always lasts at least one cycle after a delivery. This gives the PC the edge on which `fetch_flag` is seen to update `i_addr`.
- **Minimum latency:** with `mem_ack` tied high, IDLE (1) + FETCH (4) + DONE (≥1) gives 6 cycles from IDLE entry to `fetch_flag`, so at best one instruction per 6 cycles.
- **Misaligned path:** IDLE → DONE, so `instr_valid` rises 1 cycle after IDLE.
- **Combinational paths:** `mem_ack` may be asserted in the same cycle `mem_req` rises, and that beat completes in that cycle. `fetch_flag` is combinational from `instr_valid`, `instr_ready` and `flush`.
- **Reset mid-operation:** `rst_n` low in any state returns everything to reset values immediately. Any in-flight beat is abandoned, and the memory side must tolerate `mem_req` dropping.

## Structure
- Shared package `fetch_pkg` holds:
  - the state enum (IDLE, FETCH, DONE);
  - `NOP_INSTR_DEFAULT` = 32'h0000_0013;
  - `FETCH_BEATS` = 4.
- Single module, no sub-module. Beat counter, byte assembly and FSM are implemented inline.

## Test plan
- **Aligned fetch:**
  - Stimulus: `i_addr` = 0x10, memory bytes 0x10–0x13 = 93,00,50,00, `mem_ack` tied high, `instr_ready` tied high.
  - Required response: `mem_addr` steps 0x10..0x13; `instr` = 32'h0050_0093 valid on cycle 5; `fetch_flag` pulses once; `fetch_err` = 0.
- **Back-pressure:**
  - Stimulus: `instr_ready` held low for 3 cycles in DONE.
  - Required response: `instr`, `instr_valid` and `fetch_err` stable throughout; `fetch_flag` = 0 until `instr_ready` rises, then one pulse.
- **Misaligned:**
  - Stimulus: `i_addr` = 0x22.
  - Required response: no `mem_req`; `instr` = 32'h0000_0013 with `fetch_err` = 1, valid 1 cycle after IDLE.
- **Flush mid-fetch:**
  - Stimulus: `flush` after beat 1 while `mem_ack` is delayed 2 cycles.
  - Required response: `mem_req` held until that ack; no `instr_valid`; next fetch uses the new `i_addr` = 0x40.
- **Flush vs. ready:**
  - Stimulus: `flush` and `instr_ready` high in the same DONE cycle.
  - Required response: `fetch_flag` = 0; state returns to IDLE.
- **Reset mid-FETCH:**
  - Stimulus: `rst_n` low during beat 2.
  - Required response: all outputs 0 in the same cycle; after release, fetch restarts at the current `i_addr` from beat 0.
